multdiv_sequencer: RTL and testbench
====================================

// Module: multdiv_sequencer
//
// PURPOSE
//   Iteration sequencer that drives the multdiv datapath. It is the consumer and
//   controller of the iteration count: it loads a down-count, issues one step
//   strobe per datapath iteration and raises result-ready when the count expires.
//   It replaces free-running up-count decode with an explicit start/step/done
//   handshake for the shift-add multiplier and the restoring divider.
//
// PARAMETERS
//   CNT_W      6   width of the iteration counter; must hold max(MULT_ITERS,DIV_ITERS)-1
//   MULT_ITERS 16  step cycles per multiply (radix-4 Booth, 32-bit)
//   DIV_ITERS  32  step cycles per divide (restoring, 32-bit)
//
// PORTS
//   clock         in   1      single rising-edge clock
//   reset         in   1      asynchronous, active-high reset
//   ctrl_MULT     in   1      start multiply; sampled each rising edge
//   ctrl_DIV      in   1      start divide; sampled each rising edge
//   hold          in   1      freeze iteration (only with MULTDIV_STALL_EN)
//   busy          out  1      high in RUN and DONE
//   is_div        out  1      op type latched at start: 1=divide, 0=multiply
//   step          out  1      datapath performs one iteration this cycle
//   first         out  1      first step of an operation; datapath loads operands
//   iter          out  CNT_W  remaining-iteration index, counts N-1 down to 0
//   result_ready  out  1      one-cycle pulse: datapath result is valid
//
// BEHAVIOUR
//   - Reset (async, any time incl. mid-op): state=IDLE; busy, is_div, step, first,
//     result_ready = 0; iter = 0. Outputs follow reset immediately.
//   - States: IDLE, RUN, DONE. Registered state and iter; outputs decoded from state.
//   - Start: edge E0 samples ctrl_MULT|ctrl_DIV=1 -> state=RUN, iter=N-1, is_div
//     latched, first=1 for cycle 1 only. N=MULT_ITERS or DIV_ITERS.
//   - RUN: step=1 every cycle; each edge iter<=iter-1. At iter==0 the next edge
//     goes to DONE. The cycle after E0 is step cycle 1; step cycles are 1..N.
//   - DONE: exactly one cycle; result_ready=1, step=0, busy=1. Next edge -> IDLE.
//     Latency: result_ready is high in cycle N+1 after the start edge.
//   - IDLE: step=0, busy=0, iter holds 0; is_div keeps the last op type.
//   - Simultaneous ctrl_MULT and ctrl_DIV: multiply wins; ctrl_DIV is ignored.
//   - Start while RUN or DONE: the operation restarts. iter reloads to N-1 and
//     first=1 next cycle. A DONE pulse already in progress is still emitted in
//     that cycle. No result_ready occurs for the aborted op in any later cycle.
//   - Start held high several cycles: each sampled edge restarts. The op completes
//     N+1 cycles after the last sampled start.
//   - iter never underflows. Values >= N never appear.
//
// CONFIGURATION
//   MULTDIV_STALL_EN defined: hold port exists. In RUN with hold=1: step=0,
//     iter and state frozen, first stays asserted if not yet consumed. A start
//     still restarts. hold is ignored in IDLE and DONE. Latency = N+1+held cycles.
//   MULTDIV_STALL_EN undefined: hold port absent. Behaviour is as if hold=0.
//
// TESTING
//   1. ctrl_MULT pulse 1 cycle -> first=1 cycle 1; step high 16 cycles;
//      iter 15..0; result_ready only in cycle 17; is_div=0.
//   2. ctrl_DIV pulse -> 32 step cycles, iter 31..0, result_ready in cycle 33,
//      is_div=1 held through IDLE after.
//   3. ctrl_MULT=ctrl_DIV=1 same edge -> is_div=0, 16 steps.
//   4. ctrl_DIV at step cycle 10 of a multiply -> iter reloads 31, first=1,
//      single result_ready at cycle 33 after that edge, none for the multiply.
//   5. reset asserted mid-RUN (iter=7), asynchronous to clock -> all outputs 0
//      immediately; after release, ctrl_MULT works normally (test 1 repeats).
//   6. [STALL_EN] multiply with hold=1 for 3 cycles at iter=5 -> iter stays 5,
//      step=0 for 3 cycles, result_ready in cycle 20.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// ---------------------------------------------------------------------------
// multdiv_sequencer
//
// Iteration sequencer for the multdiv datapath. A start request loads a
// down-counter with the iteration count of the requested operation, the
// sequencer then issues one step strobe per datapath iteration and finally
// raises a one-cycle result_ready pulse.
//
// Optional feature macro: MULTDIV_STALL_EN
//   defined   -> 'hold' input exists and freezes iteration while in RUN
//   undefined -> no 'hold' input, the sequencer never stalls
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   ctrl_MULT     in   start a multiply (wins over ctrl_DIV)
//   ctrl_DIV      in   start a divide
//   hold          in   freeze iteration while in RUN (MULTDIV_STALL_EN only)
//   busy          out  high in RUN and DONE
//   is_div        out  op type of the last started operation (1 = divide)
//   step          out  datapath performs one iteration this cycle
//   first         out  first step of an operation; datapath loads operands
//   iter          out  remaining-iteration index, N-1 down to 0
//   result_ready  out  one-cycle pulse, datapath result is valid
// ---------------------------------------------------------------------------
module multdiv_sequencer #(
    parameter int CNT_W      = 6,
    parameter int MULT_ITERS = 16,
    parameter int DIV_ITERS  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
`ifdef MULTDIV_STALL_EN
    input  logic             hold,
`endif
    output logic             busy,
    output logic             is_div,
    output logic             step,
    output logic             first,
    output logic [CNT_W-1:0] iter,
    output logic             result_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_ITERS - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_ITERS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             isDiv_q, isDiv_d;
    logic             first_q, first_d;
    logic             stall;
    logic             startReq;

`ifdef MULTDIV_STALL_EN
    assign stall = hold;
`else
    assign stall = 1'b0;
`endif

    assign startReq = ctrl_MULT | ctrl_DIV;

    // Next-state logic. A start request overrides whatever is in progress,
    // so an aborted operation never reaches DONE. A stall only matters in
    // RUN; while stalled, 'first' is kept so the datapath still sees the
    // operand-load strobe on the first step it actually performs.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        isDiv_d = isDiv_q;
        first_d = first_q;
        if (startReq) begin
            state_d = RUN;
            isDiv_d = ~ctrl_MULT;
            iter_d  = ctrl_MULT ? MULT_LAST : DIV_LAST;
            first_d = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (!stall) begin
                        first_d = 1'b0;
                        if (iter_q == '0) begin
                            state_d = DONE;
                        end else begin
                            iter_d = iter_q - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    // State register; reset takes effect immediately, even mid-operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            iter_q  <= '0;
            isDiv_q <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            isDiv_q <= isDiv_d;
            first_q <= first_d;
        end
    end

    // Strobes decoded from the registered state; step drops while stalled.
    assign busy         = (state_q != IDLE);
    assign step         = (state_q == RUN) && !stall;
    assign result_ready = (state_q == DONE);
    assign first        = first_q;
    assign is_div       = isDiv_q;
    assign iter         = iter_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multdiv_sequencer
//
// Self-checking bench for multdiv_sequencer. A behavioural model counts the
// step cycles completed by the current operation and derives every output
// from that count; a compare process checks the DUT against it on every
// falling edge. Directed scenarios pin the model with literal expectations,
// followed by a randomized phase. Build with MULTDIV_STALL_EN to also
// exercise the hold input.
// ---------------------------------------------------------------------------
module tb_multdiv_sequencer;

    localparam int CNT_W  = 6;
    localparam int MULT_N = 16;
    localparam int DIV_N  = 32;

    logic             clock;
    logic             reset;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic             hold;
    logic             holdEff;
    logic             busy;
    logic             is_div;
    logic             step;
    logic             first;
    logic [CNT_W-1:0] iter;
    logic             result_ready;

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 1'b0;

    // Behavioural model: is an op in flight, its type, its length and how
    // many step cycles it has completed so far.
    bit mActive = 1'b0;
    bit mIsDiv  = 1'b0;
    int mN      = 0;
    int mSteps  = 0;

    multdiv_sequencer #(
        .CNT_W      (CNT_W),
        .MULT_ITERS (MULT_N),
        .DIV_ITERS  (DIV_N)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ctrl_MULT    (ctrl_MULT),
        .ctrl_DIV     (ctrl_DIV),
`ifdef MULTDIV_STALL_EN
        .hold         (hold),
`endif
        .busy         (busy),
        .is_div       (is_div),
        .step         (step),
        .first        (first),
        .iter         (iter),
        .result_ready (result_ready)
    );

`ifdef MULTDIV_STALL_EN
    assign holdEff = hold;
`else
    assign holdEff = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update: a start always begins a fresh op; otherwise a running op
    // gains one completed step per non-held cycle and retires one cycle after
    // its last step.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mActive <= 1'b0;
            mIsDiv  <= 1'b0;
            mN      <= 0;
            mSteps  <= 0;
        end else if (ctrl_MULT || ctrl_DIV) begin
            mActive <= 1'b1;
            mIsDiv  <= !ctrl_MULT;
            mN      <= ctrl_MULT ? MULT_N : DIV_N;
            mSteps  <= 0;
        end else if (mActive) begin
            if (mSteps == mN) begin
                mActive <= 1'b0;
            end else if (!holdEff) begin
                mSteps <= mSteps + 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (checkEn) begin
            int eBusy, eStep, eFirst, eIter, eRdy;
            eBusy = 0; eStep = 0; eFirst = 0; eIter = 0; eRdy = 0;
            if (mActive) begin
                eBusy = 1;
                if (mSteps < mN) begin
                    eStep  = holdEff ? 0 : 1;
                    eFirst = (mSteps == 0) ? 1 : 0;
                    eIter  = mN - 1 - mSteps;
                end else begin
                    eRdy = 1;
                end
            end
            checkVal("cyc.busy", int'(busy), eBusy);
            checkVal("cyc.is_div", int'(is_div), int'(mIsDiv));
            checkVal("cyc.step", int'(step), eStep);
            checkVal("cyc.first", int'(first), eFirst);
            checkVal("cyc.iter", int'(iter), eIter);
            checkVal("cyc.result_ready", int'(result_ready), eRdy);
        end
    end

    // Starts an op at the next edge, then runs 'budget' cycles counted from
    // that edge (cycle 1 = first cycle after it). Optional restart and hold
    // window are given in the same cycle numbering; 0 disables them.
    task automatic applyStimulus(
        input  bit doMult, input bit doDiv,
        input  int restartAt, input bit restartDiv,
        input  int holdAt, input int holdLen,
        input  int probeAt, input int budget,
        output int steps, output int firstCnt, output int rrAt,
        output int rrCnt, output int probeIter);
        steps = 0; firstCnt = 0; rrAt = -1; rrCnt = 0; probeIter = -1;
        ctrl_MULT = doMult;
        ctrl_DIV  = doDiv;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            hold      = (holdLen > 0) && (k >= holdAt) && (k < holdAt + holdLen);
            ctrl_DIV  = (k == restartAt) && restartDiv;
            ctrl_MULT = (k == restartAt) && !restartDiv;
            @(negedge clock);
            if (step) steps++;
            if (first) firstCnt++;
            if (result_ready) begin
                rrCnt++;
                rrAt = k;
            end
            if (k == probeAt) probeIter = int'(iter);
            @(posedge clock); #1;
        end
        hold      = 1'b0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input int steps, input int firstCnt,
                               input int rrAt, input int rrCnt,
                               input int eSteps, input int eFirst, input int eRrAt);
        checkVal({tag, ".steps"}, steps, eSteps);
        checkVal({tag, ".firstCount"}, firstCnt, eFirst);
        checkVal({tag, ".readyCycle"}, rrAt, eRrAt);
        checkVal({tag, ".readyCount"}, rrCnt, 1);
    endtask

    initial begin
        int steps, firstCnt, rrAt, rrCnt, probeIter;
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        hold      = 1'b0;
        #1 reset  = 1'b1;
        checkEn   = 1'b1;
        repeat (2) @(negedge clock);
        checkVal("reset.busy", int'(busy), 0);
        checkVal("reset.iter", int'(iter), 0);
        checkVal("reset.is_div", int'(is_div), 0);
        #2 reset = 1'b0;
        @(posedge clock); #1;

        $display("[TB] test 1: multiply");
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 20, steps, firstCnt, rrAt, rrCnt, probeIter);
        checkOutput("t1", steps, firstCnt, rrAt, rrCnt, 16, 1, 17);
        checkVal("t1.firstIter", probeIter, 15);
        checkVal("t1.is_div", int'(is_div), 0);

        $display("[TB] test 2: divide");
        applyStimulus(0, 1, 0, 0, 0, 0, 32, 36, steps, firstCnt, rrAt, rrCnt, probeIter);
        checkOutput("t2", steps, firstCnt, rrAt, rrCnt, 32, 1, 33);
        checkVal("t2.lastIter", probeIter, 0);
        checkVal("t2.idleIsDiv", int'(is_div), 1);
        checkVal("t2.idleBusy", int'(busy), 0);

        $display("[TB] test 3: simultaneous start");
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 20, steps, firstCnt, rrAt, rrCnt, probeIter);
        checkOutput("t3", steps, firstCnt, rrAt, rrCnt, 16, 1, 17);
        checkVal("t3.is_div", int'(is_div), 0);

        $display("[TB] test 4: divide restarts multiply at step 10");
        applyStimulus(1, 0, 10, 1, 0, 0, 11, 46, steps, firstCnt, rrAt, rrCnt, probeIter);
        checkOutput("t4", steps, firstCnt, rrAt, rrCnt, 42, 2, 43);
        checkVal("t4.reloadIter", probeIter, 31);

        $display("[TB] test 5: asynchronous reset mid-run");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 8, steps, firstCnt, rrAt, rrCnt, probeIter);
        checkVal("t5.preIter", int'(iter), 7);
        #1 reset = 1'b1;
        #1;
        checkVal("t5.busy", int'(busy), 0);
        checkVal("t5.step", int'(step), 0);
        checkVal("t5.iter", int'(iter), 0);
        checkVal("t5.first", int'(first), 0);
        @(negedge clock); #2 reset = 1'b0;
        @(posedge clock); #1;
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 20, steps, firstCnt, rrAt, rrCnt, probeIter);
        checkOutput("t5r", steps, firstCnt, rrAt, rrCnt, 16, 1, 17);

`ifdef MULTDIV_STALL_EN
        $display("[TB] test 6: hold for 3 cycles at iter 5");
        applyStimulus(1, 0, 0, 0, 11, 3, 13, 22, steps, firstCnt, rrAt, rrCnt, probeIter);
        checkOutput("t6", steps, firstCnt, rrAt, rrCnt, 16, 1, 20);
        checkVal("t6.heldIter", probeIter, 5);
`endif

        $display("[TB] random phase");
        for (int c = 0; c < 1500; c++) begin
            int r;
            r = int'($urandom_range(0, 39));
            ctrl_MULT = (r == 0) || (r == 3);
            ctrl_DIV  = (r == 1) || (r == 2) || (r == 3);
`ifdef MULTDIV_STALL_EN
            hold = ($urandom_range(0, 3) == 0);
`endif
            if (r == 39 && $urandom_range(0, 3) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            @(posedge clock); #1;
        end
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        hold      = 1'b0;
        repeat (40) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
